// File: rtl/vga_pkg.sv
// vga_pkg: shared timing constants, colour palette and box-axis step helper
package vga_pkg;
    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;
    localparam int R_W = 3;
    localparam int G_W = 3;
    localparam int B_W = 2;
    localparam int RGB_W = R_W + G_W + B_W;
    localparam logic [RGB_W-1:0] BG_COLOR = 8'h00;
    localparam logic [RGB_W-1:0] BORDER_COLOR = 8'hFF;
    // index 0 is the LSB slot: red, green, blue, yellow
    localparam logic [3:0][RGB_W-1:0] PALETTE = {8'hFC, 8'h03, 8'h1C, 8'hE0};

    // returns {bounce, neg_next, pos_next} for one frame step on one axis
    function automatic logic [11:0] axis_step(input logic [9:0] pos, input logic neg,
                                              input int max_pos, input int speed);
        logic [10:0] p, s, m;
        p = {1'b0, pos};
        s = 11'(speed);
        m = 11'(max_pos);
        if (!neg)
            axis_step = (p + s >= m) ? {2'b11, m[9:0]} : {2'b00, pos + s[9:0]};
        else
            axis_step = (p <= s) ? {2'b10, 10'd0} : {2'b01, pos - s[9:0]};
    endfunction
endpackage

// File: rtl/box_motion.sv
// box_motion: per-frame box position, bounce directions and colour index
module box_motion #(
    parameter int MAX_X = 608,
    parameter int MAX_Y = 448,
    parameter int SPEED = 2
)(
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    output logic [9:0] box_x,
    output logic [9:0] box_y,
    output logic [1:0] color_idx
);
    import vga_pkg::*;

    logic neg_x, neg_y;
    logic [11:0] nx, ny;

    always_comb begin
        nx = axis_step(box_x, neg_x, MAX_X, SPEED);
        ny = axis_step(box_y, neg_y, MAX_Y, SPEED);
    end

    // a corner hit bounces both axes but advances the colour only once
    always_ff @(posedge clock) begin
        if (reset) begin
            box_x <= '0;
            box_y <= '0;
            neg_x <= 1'b0;
            neg_y <= 1'b0;
            color_idx <= '0;
        end else if (tick) begin
            box_x <= nx[9:0];
            box_y <= ny[9:0];
            neg_x <= nx[10];
            neg_y <= ny[10];
            color_idx <= color_idx + 2'(nx[11] | ny[11]);
        end
    end
endmodule

// File: rtl/box_pixel_gen.sv
// box_pixel_gen: bouncing square plus white border, RGB and syncs aligned
// through a 2-stage pipeline behind the VGA sync controller
module box_pixel_gen #(
    parameter int H_VISIBLE = 640,
    parameter int V_VISIBLE = 480,
    parameter int BOX_SIZE = 32,
    parameter int SPEED = 2,
    parameter int SYNC_ACTIVE_LOW = 1
)(
    input  logic       clock,
    input  logic       reset,
    input  logic       hs_in,
    input  logic       vs_in,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       video,
    output logic       hs_out,
    output logic       vs_out,
    output logic [7:0] rgb
);
    import vga_pkg::*;

    localparam logic ACT = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic IDLE = ~ACT;

    logic video_d, hs_d, vs_d, in_box, on_border, armed, tick;
    logic box_hit, border_hit;
    logic [9:0] box_x, box_y;
    logic [1:0] color_idx;
    logic [10:0] xe, ye, bx, by;

    // vs_d doubles as the stage-1 vs copy and the edge-detect history;
    // armed suppresses a false edge when vs is already active at reset release
    assign tick = armed && vs_in == ACT && vs_d == IDLE;

    always_comb begin
        xe = {1'b0, x};
        ye = {1'b0, y};
        bx = {1'b0, box_x};
        by = {1'b0, box_y};
        box_hit = xe >= bx && xe < bx + 11'(BOX_SIZE) && ye >= by && ye < by + 11'(BOX_SIZE);
        border_hit = x == 10'(H_VISIBLE-1) || x == 10'd0 || y == 10'd0 || y == 10'(V_VISIBLE-1);
    end

    box_motion #(
        .MAX_X(H_VISIBLE - BOX_SIZE),
        .MAX_Y(V_VISIBLE - BOX_SIZE),
        .SPEED(SPEED)
    ) u_motion (
        .clock(clock),
        .reset(reset),
        .tick(tick),
        .box_x(box_x),
        .box_y(box_y),
        .color_idx(color_idx)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            video_d <= 1'b0;
            hs_d <= IDLE;
            vs_d <= IDLE;
            in_box <= 1'b0;
            on_border <= 1'b0;
            armed <= 1'b0;
        end else begin
            video_d <= video;
            hs_d <= hs_in;
            vs_d <= vs_in;
            in_box <= box_hit;
            on_border <= border_hit;
            armed <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rgb <= 8'h00;
            hs_out <= IDLE;
            vs_out <= IDLE;
        end else begin
            rgb <= !video_d ? 8'h00 : on_border ? BORDER_COLOR : in_box ? PALETTE[color_idx] : BG_COLOR;
            hs_out <= hs_d;
            vs_out <= vs_d;
        end
    end
endmodule

// File: tb/tb_box_pixel_gen.sv
// tb_box_pixel_gen: directed stimulus with a closed-form frame model checked every cycle
module tb_box_pixel_gen;
    localparam int HV = 640, VV = 480, BS = 32, SPD = 2;
    localparam int MX = HV - BS, MY = VV - BS;

    logic clock = 1'b0, reset = 1'b1;
    logic hs_in = 1'b1, vs_in = 1'b1, video = 1'b0;
    logic [9:0] x = '0, y = '0;
    logic hs_out, vs_out;
    logic [7:0] rgb;

    int checks = 0, failures = 0;
    int m_ticks = 0, dut_ticks = 0, bx, by, rec;
    bit started = 0, m_prev_ok = 0;
    logic m_prev_vs;
    bit s1_video, s1_hs, s1_vs, s1_inbox, s1_border;
    int exp_rgb = 0, exp_hs = 1, exp_vs = 1;

    box_pixel_gen dut (
        .clock(clock), .reset(reset), .hs_in(hs_in), .vs_in(vs_in),
        .x(x), .y(y), .video(video),
        .hs_out(hs_out), .vs_out(vs_out), .rgb(rgb)
    );

    always #20 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // each axis is a triangle wave of period 2*MAX/SPEED ticks
    function automatic int tri_pos(input int n, input int mx);
        int p, ph;
        p = mx / SPD;
        ph = n % (2 * p);
        return (ph <= p) ? SPD * ph : SPD * (2 * p - ph);
    endfunction

    // colour = number of ticks that bounced at least one axis, mod 4
    function automatic int color_of(input int n);
        int px, py, l;
        px = MX / SPD;
        py = MY / SPD;
        l = px;
        while (l % py != 0) l += px;
        return (n / px + n / py - n / l) % 4;
    endfunction

    function automatic int pal(input int i);
        case (i)
            0: return 'hE0;
            1: return 'h1C;
            2: return 'h03;
            default: return 'hFC;
        endcase
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            {s1_video, s1_inbox, s1_border} = 3'b000;
            s1_hs = 1; s1_vs = 1;
            exp_rgb = 0; exp_hs = 1; exp_vs = 1;
            m_ticks = 0; m_prev_ok = 0; started = 1;
        end else begin
            bx = tri_pos(m_ticks, MX);
            by = tri_pos(m_ticks, MY);
            exp_rgb = !s1_video ? 0 : s1_border ? 'hFF : s1_inbox ? pal(color_of(m_ticks)) : 0;
            exp_hs = s1_hs;
            exp_vs = s1_vs;
            s1_video = video; s1_hs = hs_in; s1_vs = vs_in;
            s1_inbox = int'(x) >= bx && int'(x) < bx + BS && int'(y) >= by && int'(y) < by + BS;
            s1_border = x == 0 || x == HV - 1 || y == 0 || y == VV - 1;
            if (m_prev_ok && vs_in == 1'b0 && m_prev_vs == 1'b1) m_ticks++;
            m_prev_vs = vs_in;
            m_prev_ok = 1;
        end
    end

    always @(negedge clock) begin
        if (dut.tick === 1'b1) dut_ticks++;
        if (started) begin
            chk("rgb", rgb, exp_rgb);
            chk("hs_out", hs_out, exp_hs);
            chk("vs_out", vs_out, exp_vs);
            chk("box_x", dut.u_motion.box_x, tri_pos(m_ticks, MX));
            chk("box_y", dut.u_motion.box_y, tri_pos(m_ticks, MY));
            chk("color_idx", dut.u_motion.color_idx, color_of(m_ticks));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic vs_pulse(input int act_cyc, input int idle_cyc);
        vs_in = 1'b0;
        step(act_cyc);
        vs_in = 1'b1;
        step(idle_cyc);
    endtask

    int tx[8] = '{0, 639, 320, 320, 320, 31, 32, 0};
    int ty[8] = '{200, 200, 479, 0, 200, 31, 10, 200};
    int tv[8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    int te[8] = '{'hFF, 'hFF, 'hFF, 'hFF, 'h00, 'hE0, 'h00, 'h00};

    initial begin
        for (int i = 0; i < 3; i++) begin
            step(1);
            x = 10'($urandom_range(0, 1023));
            y = 10'($urandom_range(0, 1023));
            video = 1'($urandom);
            hs_in = 1'($urandom);
            vs_in = 1'($urandom);
        end
        step(1);
        chk("reset_rgb", rgb, 0);
        chk("reset_hs", hs_out, 1);
        chk("reset_vs", vs_out, 1);
        chk("reset_box_x", dut.u_motion.box_x, 0);
        chk("reset_box_y", dut.u_motion.box_y, 0);
        chk("reset_color", dut.u_motion.color_idx, 0);
        hs_in = 1'b1; vs_in = 1'b1;
        reset = 1'b0;
        x = 10; y = 10; video = 1'b1;
        step(1);
        chk("lat_n1", rgb, 0);
        step(1);
        chk("lat_n2", rgb, 'hE0);
        video = 1'b0;
        step(2);
        chk("lat_video0", rgb, 0);
        hs_in = 1'b0;
        step(1);
        chk("hs_n1", hs_out, 1);
        step(1);
        chk("hs_n2", hs_out, 0);
        hs_in = 1'b1;
        step(2);
        for (int i = 0; i < 8; i++) begin
            x = 10'(tx[i]); y = 10'(ty[i]); video = 1'(tv[i]);
            step(2);
            chk($sformatf("pix_%0d_%0d", tx[i], ty[i]), rgb, te[i]);
        end
        video = 1'b0;
        for (int i = 0; i < 5; i++) vs_pulse(1600, 200);
        chk("motion_ticks", dut_ticks, 5);
        chk("motion_x", dut.u_motion.box_x, 10);
        chk("motion_y", dut.u_motion.box_y, 10);
        chk("motion_color", dut.u_motion.color_idx, 0);
        for (int i = 0; i < 218; i++) vs_pulse(2, 2);
        chk("t223_y", dut.u_motion.box_y, 446);
        chk("t223_color", dut.u_motion.color_idx, 0);
        vs_pulse(2, 2);
        chk("t224_y", dut.u_motion.box_y, 448);
        chk("t224_color", dut.u_motion.color_idx, 1);
        for (int i = 0; i < 80; i++) vs_pulse(2, 2);
        chk("t304_x", dut.u_motion.box_x, 608);
        chk("t304_color", dut.u_motion.color_idx, 2);
        vs_pulse(2, 2);
        chk("t305_x", dut.u_motion.box_x, 606);
        for (int i = 0; i < 3950; i++) vs_pulse(2, 2);
        chk("t4255_x", dut.u_motion.box_x, 2);
        chk("t4255_y", dut.u_motion.box_y, 446);
        chk("t4255_color", dut.u_motion.color_idx, 3);
        vs_pulse(2, 2);
        chk("corner_x", dut.u_motion.box_x, 0);
        chk("corner_y", dut.u_motion.box_y, 448);
        chk("corner_color", dut.u_motion.color_idx, 0);
        vs_pulse(2, 2);
        chk("after_corner_x", dut.u_motion.box_x, 2);
        chk("after_corner_y", dut.u_motion.box_y, 446);
        chk("total_ticks", dut_ticks, 4257);
        x = 10; y = 10; video = 1'b1;
        vs_in = 1'b0;
        step(3);
        reset = 1'b1;
        step(1);
        chk("midreset_rgb", rgb, 0);
        chk("midreset_vs", vs_out, 1);
        step(1);
        rec = dut_ticks;
        reset = 1'b0;
        step(1);
        chk("refill_n1", rgb, 0);
        step(1);
        chk("refill_n2", rgb, 'hE0);
        step(8);
        chk("no_tick_held_vs", dut_ticks, rec);
        chk("held_vs_box_x", dut.u_motion.box_x, 0);
        vs_in = 1'b1;
        step(2);
        vs_in = 1'b0;
        step(2);
        chk("tick_after_edge", dut_ticks, rec + 1);
        chk("edge_box_x", dut.u_motion.box_x, 2);
        chk("edge_box_y", dut.u_motion.box_y, 2);
        vs_in = 1'b1;
        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
